// File: rtl/cpu_bus_sequencer.sv
// Turns per-M-cycle control from the CPU control unit into a 4-T-cycle bus access.
// Owns PC and IR; one request is latched per M-cycle at the phase-3 boundary edge.
module cpu_bus_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [1:0]  pc_update,
  input  logic        load_instruction_register,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic        addr_from_pc,
  input  logic [15:0] mem_addr_in,
  input  logic [7:0]  mem_wdata_in,
  input  logic [15:0] pc_load_value,
  input  logic [7:0]  bus_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [15:0] pc,
  output logic [7:0]  instruction_register,
  output logic [7:0]  read_data,
  output logic [1:0]  t_phase,
  output logic        m_cycle_end
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} phase_t;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic        ld_ir;
    logic [1:0]  upd;
    logic        from_pc;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  localparam logic [1:0] UPD_INC  = 2'd1;
  localparam logic [1:0] UPD_LOAD = 2'd2;
  localparam req_t REQ_IDLE = '{en: 1'b0, wr: 1'b0, ld_ir: 1'b0, upd: 2'd0,
                                from_pc: 1'b1, addr: 16'h0000, wdata: 8'h00};

  phase_t      phase;
  req_t        req;
  logic [15:0] pc_q;
  logic [7:0]  ir_q;
  logic [7:0]  rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= T0;
      req     <= REQ_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      rdata_q <= 8'h00;
    end else if (ce) begin
      case (phase)
        T3: begin
          // PC update belongs to the ending M-cycle; reserved code 3 holds like Same
          if (req.upd == UPD_INC)       pc_q <= pc_q + 16'd1;
          else if (req.upd == UPD_LOAD) pc_q <= pc_load_value;
          req <= '{en: mem_enable, wr: mem_write, ld_ir: load_instruction_register,
                   upd: pc_update, from_pc: addr_from_pc, addr: mem_addr_in,
                   wdata: mem_wdata_in};
          phase <= T0;
        end
        T2: begin
          if (req.en && !req.wr) begin
            rdata_q <= bus_rdata;
            if (req.ld_ir) ir_q <= bus_rdata;
          end
          phase <= T3;
        end
        T1:      phase <= T2;
        default: phase <= T1;
      endcase
    end
  end

  // Strobes decode straight from registered state so reset drops them immediately
  assign bus_rd      = req.en && !req.wr && (phase != T3);
  assign bus_wr      = req.en && req.wr && ((phase == T1) || (phase == T2));
  assign bus_addr    = req.from_pc ? pc_q : req.addr;
  assign bus_wdata   = req.wdata;
  assign pc          = pc_q;
  assign instruction_register = ir_q;
  assign read_data   = rdata_q;
  assign t_phase     = phase;
  assign m_cycle_end = ce && (phase == T3);

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: per-T-cycle vector table plus reset corner cases.
module tb_cpu_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [1:0]  pc_update;
  logic        load_instruction_register;
  logic        mem_enable;
  logic        mem_write;
  logic        addr_from_pc;
  logic [15:0] mem_addr_in;
  logic [7:0]  mem_wdata_in;
  logic [15:0] pc_load_value;
  logic [7:0]  bus_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] pc;
  logic [7:0]  instruction_register;
  logic [7:0]  read_data;
  logic [1:0]  t_phase;
  logic        m_cycle_end;

  cpu_bus_sequencer #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pc_update(pc_update),
    .load_instruction_register(load_instruction_register),
    .mem_enable(mem_enable), .mem_write(mem_write), .addr_from_pc(addr_from_pc),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
    .pc_load_value(pc_load_value), .bus_rdata(bus_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .pc(pc), .instruction_register(instruction_register), .read_data(read_data),
    .t_phase(t_phase), .m_cycle_end(m_cycle_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [1:0]  upd;
    logic        ld, en, wr, fpc;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [15:0] pcl;
    logic [7:0]  rdata;
    logic [1:0]  e_ph;
    logic        e_rd, e_wr, e_mce;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    logic [15:0] e_pc;
    logic [7:0]  e_ir, e_rdat;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(
    logic c, logic [1:0] u, logic l, logic n, logic w, logic f, logic [15:0] a,
    logic [7:0] d, logic [15:0] pl, logic [7:0] rd,
    logic [1:0] eph, logic erd, logic ewr, logic emce, logic [15:0] ea,
    logic [7:0] ewd, logic [15:0] epc, logic [7:0] eir, logic [7:0] erdat);
    vec_t v;
    v.ce = c; v.upd = u; v.ld = l; v.en = n; v.wr = w; v.fpc = f; v.addr = a;
    v.wd = d; v.pcl = pl; v.rdata = rd; v.e_ph = eph; v.e_rd = erd; v.e_wr = ewr;
    v.e_mce = emce; v.e_addr = ea; v.e_wd = ewd; v.e_pc = epc; v.e_ir = eir;
    v.e_rdat = erdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ce = 1'b1; pc_update = 2'd0; load_instruction_register = 1'b0; mem_enable = 1'b0;
    mem_write = 1'b0; addr_from_pc = 1'b0; mem_addr_in = 16'h0000;
    mem_wdata_in = 8'h00; pc_load_value = 16'h0000; bus_rdata = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    drive_idle();
    // idle M-cycle, then a fetch of C3 at PC
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h00, 0,0,0,0,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h00, 1,0,0,0,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h00, 2,0,0,0,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    vecs.push_back(mk(1,1,1,1,0,1,16'h0000,8'h00,16'h0000,8'hC3, 3,0,0,1,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'hC3, 0,1,0,0,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'hC3, 1,1,0,0,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'hC3, 2,1,0,0,16'h0100,8'h00,16'h0100,8'h00,8'h00));
    // write FF80 <- 5A with load_ir set: IR must not capture
    vecs.push_back(mk(1,0,1,1,1,0,16'hFF80,8'h5A,16'h0000,8'h77, 3,0,0,1,16'h0100,8'h00,16'h0100,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h77, 0,0,0,0,16'hFF80,8'h5A,16'h0101,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h77, 1,0,1,0,16'hFF80,8'h5A,16'h0101,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h77, 2,0,1,0,16'hFF80,8'h5A,16'h0101,8'hC3,8'hC3));
    // Load FFFF (live value at the ending boundary wins over 1234)
    vecs.push_back(mk(1,2,0,0,0,1,16'h0000,8'h00,16'h1111,8'h77, 3,0,0,1,16'hFF80,8'h5A,16'h0101,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 0,0,0,0,16'h0101,8'h00,16'h0101,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 1,0,0,0,16'h0101,8'h00,16'h0101,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 2,0,0,0,16'h0101,8'h00,16'h0101,8'hC3,8'hC3));
    vecs.push_back(mk(1,1,0,0,0,1,16'h0000,8'h00,16'hFFFF,8'h77, 3,0,0,1,16'h0101,8'h00,16'h0101,8'hC3,8'hC3));
    // Inc from FFFF wraps to 0000
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h77, 0,0,0,0,16'hFFFF,8'h00,16'hFFFF,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h77, 1,0,0,0,16'hFFFF,8'h00,16'hFFFF,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h77, 2,0,0,0,16'hFFFF,8'h00,16'hFFFF,8'hC3,8'hC3));
    vecs.push_back(mk(1,2,0,0,0,1,16'h0000,8'h00,16'h1234,8'h77, 3,0,0,1,16'hFFFF,8'h00,16'hFFFF,8'hC3,8'hC3));
    // Load: pc_load_value 1234 changed to 4321 just before the boundary
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 0,0,0,0,16'h0000,8'h00,16'h0000,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 1,0,0,0,16'h0000,8'h00,16'h0000,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 2,0,0,0,16'h0000,8'h00,16'h0000,8'hC3,8'hC3));
    vecs.push_back(mk(1,3,0,0,0,1,16'h0000,8'h00,16'h4321,8'h77, 3,0,0,1,16'h0000,8'h00,16'h0000,8'hC3,8'hC3));
    // reserved update holds
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 0,0,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 1,0,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h1234,8'h77, 2,0,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,1,0,0,1,16'h0000,8'h00,16'h1234,8'h99, 3,0,0,1,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    // idle M-cycle with load_ir but no read: IR and read_data hold
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h99, 0,0,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h99, 1,0,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h99, 2,0,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,1,1,1,0,1,16'h0000,8'h00,16'h0000,8'h5E, 3,0,0,1,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    // fetch with ce pulsing 1-in-3; junk inputs while ce=0 are ignored
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 0,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(0,2,1,1,1,0,16'hAAAA,8'hEE,16'hBEEF,8'h5E, 1,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(0,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 1,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 1,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(0,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 2,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(0,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 2,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(1,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 2,1,0,0,16'h4321,8'h00,16'h4321,8'hC3,8'hC3));
    vecs.push_back(mk(0,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 3,0,0,0,16'h4321,8'h00,16'h4321,8'h5E,8'h5E));
    vecs.push_back(mk(0,0,0,0,0,0,16'h0000,8'h00,16'h0000,8'h5E, 3,0,0,0,16'h4321,8'h00,16'h4321,8'h5E,8'h5E));
    // next: plain read of 8000 (no IR load)
    vecs.push_back(mk(1,0,0,1,0,0,16'h8000,8'h00,16'h0000,8'hA5, 3,0,0,1,16'h4321,8'h00,16'h4321,8'h5E,8'h5E));

    step();
    step();
    chk("rst pc", pc, 16'h0100);
    chk("rst ir", instruction_register, 8'h00);
    chk("rst read_data", read_data, 8'h00);
    chk("rst phase", t_phase, 2'd0);
    chk("rst bus_addr", bus_addr, 16'h0100);
    chk("rst strobes", {bus_rd, bus_wr}, 2'b00);
    chk("rst bus_wdata", bus_wdata, 8'h00);
    chk("rst m_cycle_end", m_cycle_end, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ce = vecs[i].ce; pc_update = vecs[i].upd; load_instruction_register = vecs[i].ld;
      mem_enable = vecs[i].en; mem_write = vecs[i].wr; addr_from_pc = vecs[i].fpc;
      mem_addr_in = vecs[i].addr; mem_wdata_in = vecs[i].wd;
      pc_load_value = vecs[i].pcl; bus_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d phase", i), t_phase, vecs[i].e_ph);
      chk($sformatf("v%0d bus_rd", i), bus_rd, vecs[i].e_rd);
      chk($sformatf("v%0d bus_wr", i), bus_wr, vecs[i].e_wr);
      chk($sformatf("v%0d m_cycle_end", i), m_cycle_end, vecs[i].e_mce);
      chk($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].e_addr);
      chk($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d ir", i), instruction_register, vecs[i].e_ir);
      chk($sformatf("v%0d read_data", i), read_data, vecs[i].e_rdat);
      step();
    end

    // read of 8000 in flight; keep the request on the inputs throughout
    chk("rd8000 ph0 strobe", bus_rd, 1'b1);
    chk("rd8000 addr", bus_addr, 16'h8000);
    chk("rd8000 pc inc", pc, 16'h4322);
    step();
    chk("rd8000 ph1 strobe", bus_rd, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst bus_rd", bus_rd, 1'b0);
    chk("async rst pc", pc, 16'h0100);
    chk("async rst phase", t_phase, 2'd0);
    chk("async rst bus_addr", bus_addr, 16'h0100);
    chk("async rst read_data", read_data, 8'h00);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post-rst idle%0d phase", k), t_phase, k[1:0]);
      chk($sformatf("post-rst idle%0d strobes", k), {bus_rd, bus_wr}, 2'b00);
      chk($sformatf("post-rst idle%0d mce", k), m_cycle_end, (k == 3));
      step();
    end
    chk("post-rst read strobe", bus_rd, 1'b1);
    chk("post-rst read addr", bus_addr, 16'h8000);
    chk("post-rst pc", pc, 16'h0100);
    drive_idle();
    bus_rdata = 8'hA5;
    step();
    step();
    step();
    chk("plain read phase", t_phase, 2'd3);
    chk("plain read data", read_data, 8'hA5);
    chk("plain read ir held", instruction_register, 8'h00);
    chk("plain read ph3 strobe", bus_rd, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
